// File: rtl/bdd_pkg.sv
// Shared definitions for the decision-tree loader and traversal engine.
// Covers the state encoding, node word layouts and frame constants.
package bdd_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_COEF,
    S_CHILD,
    S_CSUM,
    S_DONE,
    S_ERR
  } state_t;

  localparam int C1_LSB      = 26;
  localparam int C2_LSB      = 18;
  localparam int C3_LSB      = 10;
  localparam int THRESH_LSB  = 0;
  localparam int LEFT_LSB    = 8;
  localparam int RIGHT_LSB   = 0;
  localparam int LEAF_BIT    = 7;
  localparam int COEF_BYTES  = 5;
  localparam int CHILD_BYTES = 2;

endpackage

// File: rtl/byte_packer.sv
// Shifts K stream bytes into a W-bit word, oldest byte most significant.
// Only the low W bits are kept, so oversized leading bytes drop off the top.
module byte_packer #(
  parameter int K = 5,
  parameter int W = 34
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic [7:0]   data,
  output logic [W-1:0] word,
  output logic         last
);

  localparam int CW = (K > 1) ? $clog2(K) : 1;

  logic [CW-1:0] cnt;
  logic [W-9:0]  sh;

  assign word = {sh, data};
  assign last = en && (cnt == CW'(K - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      sh  <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      sh  <= word[W-9:0];
      cnt <= last ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/bdd_tree_loader.sv
// Unpacks a framed, XOR-checked tree image from a byte stream into
// the coefficient and child-pointer node memories.
module bdd_tree_loader
  import bdd_pkg::*;
#(
  parameter int RAM1_DATA_WIDTH = 34,
  parameter int RAM2_DATA_WIDTH = 16,
  parameter int ADDR_WIDTH      = 4,
  parameter int DEPTH           = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [7:0]                 s_data,
  input  logic                       s_valid,
  output logic                       s_ready,
  output logic                       we1,
  output logic [ADDR_WIDTH-1:0]      ram1_addr,
  output logic [RAM1_DATA_WIDTH-1:0] ram1_data,
  output logic                       we2,
  output logic [ADDR_WIDTH-1:0]      ram2_addr,
  output logic [RAM2_DATA_WIDTH-1:0] ram2_data,
  output logic                       busy,
  output logic                       done,
  output logic                       err
);

  state_t     state;
  logic [7:0] xsum;
  logic [7:0] n;
  logic [7:0] node;

  logic                       acc;
  logic                       arm;
  logic                       coef_last;
  logic                       child_last;
  logic [RAM1_DATA_WIDTH-1:0] coef_word;
  logic [RAM2_DATA_WIDTH-1:0] child_word;
  logic                       hdr_bad;
  logic                       ptr_bad;
  logic [7:0]                 xnext;

  assign acc   = s_valid & s_ready;
  assign arm   = start && (state == S_IDLE || state == S_DONE
                           || state == S_ERR);
  assign xnext = xsum ^ s_data;

  assign hdr_bad = (s_data == 8'd0) || (s_data > 8'(DEPTH));
  // A non-leaf child must point at a node inside this image.
  assign ptr_bad = !s_data[LEAF_BIT] && ({1'b0, s_data[6:0]} >= n);

  byte_packer #(.K(COEF_BYTES), .W(RAM1_DATA_WIDTH)) u_coef (
    .clk  (clk),
    .rst  (rst),
    .clr  (arm),
    .en   (acc && state == S_COEF),
    .data (s_data),
    .word (coef_word),
    .last (coef_last)
  );

  byte_packer #(.K(CHILD_BYTES), .W(RAM2_DATA_WIDTH)) u_child (
    .clk  (clk),
    .rst  (rst),
    .clr  (arm),
    .en   (acc && state == S_CHILD),
    .data (s_data),
    .word (child_word),
    .last (child_last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      xsum      <= '0;
      n         <= '0;
      node      <= '0;
      s_ready   <= 1'b0;
      we1       <= 1'b0;
      ram1_addr <= '0;
      ram1_data <= '0;
      we2       <= 1'b0;
      ram2_addr <= '0;
      ram2_data <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      we1 <= 1'b0;
      we2 <= 1'b0;
      if (arm) begin
        state   <= S_HDR;
        xsum    <= '0;
        s_ready <= 1'b1;
        busy    <= 1'b1;
        done    <= 1'b0;
        err     <= 1'b0;
      end else if (acc) begin
        xsum <= xnext;
        unique case (state)
          S_HDR: begin
            n    <= s_data;
            node <= '0;
            if (hdr_bad) begin
              state   <= S_ERR;
              err     <= 1'b1;
              busy    <= 1'b0;
              s_ready <= 1'b0;
            end else begin
              state <= S_COEF;
            end
          end
          S_COEF: begin
            if (coef_last) begin
              we1       <= 1'b1;
              ram1_addr <= node[ADDR_WIDTH-1:0];
              ram1_data <= coef_word;
              state     <= S_CHILD;
            end
          end
          S_CHILD: begin
            if (ptr_bad) begin
              state   <= S_ERR;
              err     <= 1'b1;
              busy    <= 1'b0;
              s_ready <= 1'b0;
            end else if (child_last) begin
              we2       <= 1'b1;
              ram2_addr <= node[ADDR_WIDTH-1:0];
              ram2_data <= child_word;
              if (node == n - 8'd1) begin
                state <= S_CSUM;
              end else begin
                node  <= node + 8'd1;
                state <= S_COEF;
              end
            end
          end
          S_CSUM: begin
            state   <= (xnext == 8'd0) ? S_DONE : S_ERR;
            done    <= (xnext == 8'd0);
            err     <= (xnext != 8'd0);
            busy    <= 1'b0;
            s_ready <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_bdd_tree_loader.sv
// Self-checking bench for bdd_tree_loader: directed frames plus
// randomized frames scored against a frame-level reference model.
module tb_bdd_tree_loader;

  typedef logic [7:0] u8;

  logic        clk = 0;
  logic        rst = 1;
  logic        start = 0;
  logic [7:0]  s_data = 0;
  logic        s_valid = 0;
  logic        s_ready;
  logic        we1;
  logic [3:0]  ram1_addr;
  logic [33:0] ram1_data;
  logic        we2;
  logic [3:0]  ram2_addr;
  logic [15:0] ram2_data;
  logic        busy;
  logic        done;
  logic        err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  int          w1a[$];
  logic [33:0] w1d[$];
  int          w1c[$];
  int          w2a[$];
  logic [15:0] w2d[$];
  int          w2c[$];

  int         consumed;
  int         end_cyc;
  int         acc_cyc[$];
  logic [3:0] st_snap;

  bdd_tree_loader dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .s_data    (s_data),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .we1       (we1),
    .ram1_addr (ram1_addr),
    .ram1_data (ram1_data),
    .we2       (we2),
    .ram2_addr (ram2_addr),
    .ram2_data (ram2_data),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (we1) begin
      w1a.push_back(int'(ram1_addr));
      w1d.push_back(ram1_data);
      w1c.push_back(cyc);
    end
    if (we2) begin
      w2a.push_back(int'(ram2_addr));
      w2d.push_back(ram2_data);
      w2c.push_back(cyc);
    end
  end

  function automatic logic [66:0] outs();
    return {s_ready, we1, ram1_addr, ram1_data, we2, ram2_addr,
            ram2_data, busy, done, err};
  endfunction

  // Pulses start, then streams bytes until the loader drops busy.
  task automatic drive_frame(input u8 f[$], input bit throttle);
    int  j = 0;
    int  to = 0;
    bit  ph = 0;
    bit  want;
    w1a.delete(); w1d.delete(); w1c.delete();
    w2a.delete(); w2d.delete(); w2c.delete();
    acc_cyc.delete();
    @(negedge clk);
    start = 1;
    @(negedge clk);
    start = 0;
    st_snap = {busy, s_ready, done, err};
    while (1) begin
      if (!busy) break;
      if (to > 2000) begin
        checks++;
        errors++;
        $display("FAIL timeout: busy still %0b after %0d cycles",
                 busy, to);
        break;
      end
      if (j < f.size()) begin
        want = throttle ? ph : 1'b1;
        ph = ~ph;
        s_valid = want;
        s_data  = f[j];
        if (want && s_ready) begin
          acc_cyc.push_back(cyc + 1);
          j++;
        end
      end else begin
        s_valid = 0;
      end
      @(negedge clk);
      to++;
    end
    s_valid  = 0;
    consumed = j;
    end_cyc  = cyc;
  endtask

  function automatic u8 xor_all(input u8 f[$]);
    u8 x = 0;
    foreach (f[i]) x ^= f[i];
    return x;
  endfunction

  task automatic test_reset();
    rst = 1;
    repeat (3) @(negedge clk);
    checks++;
    if (outs() !== 67'd0) begin
      errors++;
      $display("FAIL reset_hold: outs=%h want 0", outs());
    end
    rst = 0;
    repeat (2) @(negedge clk);
    checks++;
    if (outs() !== 67'd0) begin
      errors++;
      $display("FAIL reset_idle: outs=%h want 0", outs());
    end
  endtask

  task automatic test_basic();
    u8 f[$] = '{8'h01, 8'h03, 8'hAA, 8'hBB, 8'hCC, 8'hDD,
                8'h81, 8'h82, 8'h01};
    drive_frame(f, 0);
    checks++;
    if (st_snap !== 4'b1100) begin
      errors++;
      $display("FAIL basic_start: b/r/d/e=%b want 1100", st_snap);
    end
    checks++;
    if (consumed !== 9) begin
      errors++;
      $display("FAIL basic_consumed: got %0d want 9", consumed);
    end
    checks++;
    if (w1a.size() !== 1 || w1a[0] !== 0 || w1d[0] !== 34'h3AABBCCDD
        || w1c[0] !== acc_cyc[5]) begin
      errors++;
      $display("FAIL basic_we1: n=%0d d=%h want 1 write 3AABBCCDD",
               w1a.size(), w1d.size() ? w1d[0] : 34'h0);
    end
    checks++;
    if (w2a.size() !== 1 || w2a[0] !== 0 || w2d[0] !== 16'h8182
        || w2c[0] !== acc_cyc[7]) begin
      errors++;
      $display("FAIL basic_we2: n=%0d d=%h want 1 write 8182",
               w2a.size(), w2d.size() ? w2d[0] : 16'h0);
    end
    checks++;
    if ({done, err, busy, s_ready} !== 4'b1000
        || end_cyc !== acc_cyc[8]) begin
      errors++;
      $display("FAIL basic_done: d/e/b/r=%b cyc=%0d want 1000 cyc=%0d",
               {done, err, busy, s_ready}, end_cyc, acc_cyc[8]);
    end
  endtask

  task automatic test_bad_csum();
    u8 f[$] = '{8'h01, 8'h03, 8'hAA, 8'hBB, 8'hCC, 8'hDD,
                8'h81, 8'h82, 8'h00};
    drive_frame(f, 0);
    checks++;
    if (st_snap !== 4'b1100) begin
      errors++;
      $display("FAIL csum_start: b/r/d/e=%b want 1100", st_snap);
    end
    checks++;
    if (w1a.size() !== 1 || w2a.size() !== 1) begin
      errors++;
      $display("FAIL csum_writes: we1=%0d we2=%0d want 1 1",
               w1a.size(), w2a.size());
    end
    checks++;
    if ({done, err, busy} !== 3'b010 || end_cyc !== acc_cyc[8]) begin
      errors++;
      $display("FAIL csum_err: d/e/b=%b want 010", {done, err, busy});
    end
  endtask

  task automatic test_bad_header();
    u8 hdrs[2] = '{8'h00, 8'd17};
    for (int h = 0; h < 2; h++) begin
      u8 f[$];
      f = '{hdrs[h], 8'h01, 8'h02, 8'h03};
      drive_frame(f, 0);
      checks++;
      if (consumed !== 1 || {done, err, busy, s_ready} !== 4'b0100
          || end_cyc !== acc_cyc[0]) begin
        errors++;
        $display("FAIL hdr_%0h: used=%0d d/e/b/r=%b want 1 0100",
                 hdrs[h], consumed, {done, err, busy, s_ready});
      end
      checks++;
      if (w1a.size() + w2a.size() !== 0) begin
        errors++;
        $display("FAIL hdr_%0h_writes: got %0d want 0",
                 hdrs[h], w1a.size() + w2a.size());
      end
    end
  endtask

  task automatic test_bad_pointer();
    u8 f[$] = '{8'h02, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05,
                8'h05, 8'h81, 8'h00, 8'h00};
    drive_frame(f, 0);
    checks++;
    if (consumed !== 7 || {done, err, busy} !== 3'b010) begin
      errors++;
      $display("FAIL ptr_err: used=%0d d/e/b=%b want 7 010",
               consumed, {done, err, busy});
    end
    checks++;
    if (w1a.size() !== 1 || w2a.size() !== 0) begin
      errors++;
      $display("FAIL ptr_writes: we1=%0d we2=%0d want 1 0",
               w1a.size(), w2a.size());
    end
  endtask

  task automatic test_throttle();
    u8 f[$] = '{8'h02,
                8'h01, 8'h11, 8'h22, 8'h33, 8'h44, 8'h01, 8'h80,
                8'h02, 8'h55, 8'h66, 8'h77, 8'h88, 8'h85, 8'h86};
    f.push_back(xor_all(f));
    drive_frame(f, 1);
    checks++;
    if (consumed !== 16 || {done, err} !== 2'b10) begin
      errors++;
      $display("FAIL thr_done: used=%0d d/e=%b want 16 10",
               consumed, {done, err});
    end
    checks++;
    if (w1a.size() !== 2 || w1a[0] !== 0 || w1a[1] !== 1
        || w1d[0] !== 34'h111223344 || w1d[1] !== 34'h255667788) begin
      errors++;
      $display("FAIL thr_we1: n=%0d want addr 0,1 data 111223344,255667788",
               w1a.size());
    end
    checks++;
    if (w2a.size() !== 2 || w2a[0] !== 0 || w2a[1] !== 1
        || w2d[0] !== 16'h0180 || w2d[1] !== 16'h8586) begin
      errors++;
      $display("FAIL thr_we2: n=%0d want addr 0,1 data 0180,8586",
               w2a.size());
    end
  endtask

  task automatic test_mid_reset();
    u8 f[$] = '{8'h01, 8'h03, 8'hAA, 8'hBB};
    u8 g[$] = '{8'h01, 8'h00, 8'h10, 8'h20, 8'h30, 8'h40,
                8'h80, 8'h00};
    w1a.delete();
    @(negedge clk);
    start = 1;
    @(negedge clk);
    start = 0;
    foreach (f[i]) begin
      s_valid = 1;
      s_data  = f[i];
      @(negedge clk);
    end
    s_valid = 0;
    rst = 1;
    #1;
    checks++;
    if (outs() !== 67'd0) begin
      errors++;
      $display("FAIL rst_async: outs=%h want 0", outs());
    end
    repeat (2) @(negedge clk);
    rst = 0;
    repeat (6) @(negedge clk);
    checks++;
    if (w1a.size() !== 0 || outs() !== 67'd0) begin
      errors++;
      $display("FAIL rst_no_write: we1=%0d outs=%h want 0 0",
               w1a.size(), outs());
    end
    g.push_back(xor_all(g));
    drive_frame(g, 0);
    checks++;
    if ({done, err} !== 2'b10 || w1a.size() !== 1 || w2a.size() !== 1
        || w1d[0] !== 34'h010203040) begin
      errors++;
      $display("FAIL rst_reload: d/e=%b we1=%0d we2=%0d want 10 1 1",
               {done, err}, w1a.size(), w2a.size());
    end
  endtask

  // Reference: walks the frame record by record, applying the image rules.
  task automatic test_random(input int iters);
    for (int it = 0; it < iters; it++) begin
      u8           f[$];
      int          mode = $urandom_range(0, 3);
      int          nn;
      int          e_used;
      bit          e_done;
      int          ea[$];
      logic [33:0] ed[$];
      int          eat[$];
      int          fa[$];
      logic [15:0] fd[$];
      int          fat[$];
      int          p;
      bit          stop = 0;
      if (mode == 3)
        nn = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(17, 255);
      else
        nn = $urandom_range(1, 16);
      f.push_back(u8'(nn));
      for (int i = 0; i < ((nn >= 1 && nn <= 16) ? nn : 1); i++) begin
        for (int b = 0; b < 5; b++) f.push_back(u8'($urandom));
        for (int b = 0; b < 2; b++)
          if ($urandom_range(0, 1) || nn > 16 || nn == 0)
            f.push_back(u8'(8'h80 | $urandom_range(0, 127)));
          else
            f.push_back(u8'($urandom_range(0, nn - 1)));
      end
      if (mode == 2) begin
        p = 1 + 7 * $urandom_range(0, nn - 1) + 5 + $urandom_range(0, 1);
        f[p] = u8'($urandom_range(nn, 127));
      end
      f.push_back(xor_all(f));
      if (mode == 1) f[f.size() - 1] ^= u8'($urandom_range(1, 255));

      e_done = 0;
      if (nn == 0 || nn > 16) begin
        e_used = 1;
      end else begin
        p = 1;
        for (int i = 0; i < nn && !stop; i++) begin
          logic [39:0] c;
          c = {f[p], f[p+1], f[p+2], f[p+3], f[p+4]};
          ea.push_back(i); ed.push_back(c[33:0]); eat.push_back(p + 4);
          p += 5;
          for (int b = 0; b < 2 && !stop; b++) begin
            if (!f[p][7] && int'(f[p][6:0]) >= nn) stop = 1;
            p++;
          end
          if (!stop) begin
            fa.push_back(i); fd.push_back({f[p-2], f[p-1]});
            fat.push_back(p - 1);
          end
        end
        if (stop) begin
          e_used = p;
        end else begin
          e_used = p + 1;
          e_done = (xor_all(f[0:p]) == 8'h00);
        end
      end

      drive_frame(f, $urandom_range(0, 1));
      checks++;
      if (consumed !== e_used || {done, err} !== {e_done, !e_done}
          || busy !== 1'b0 || end_cyc !== acc_cyc[acc_cyc.size()-1]) begin
        errors++;
        $display("FAIL rnd%0d_end: used=%0d d/e=%b want %0d %b",
                 it, consumed, {done, err}, e_used, {e_done, !e_done});
      end
      checks++;
      if (w1a.size() !== ea.size() || w2a.size() !== fa.size()) begin
        errors++;
        $display("FAIL rnd%0d_count: we1=%0d we2=%0d want %0d %0d",
                 it, w1a.size(), w2a.size(), ea.size(), fa.size());
      end else begin
        foreach (ea[i]) begin
          checks++;
          if (w1a[i] !== ea[i] || w1d[i] !== ed[i]
              || w1c[i] !== acc_cyc[eat[i]]) begin
            errors++;
            $display("FAIL rnd%0d_we1[%0d]: a=%0d d=%h want %0d %h",
                     it, i, w1a[i], w1d[i], ea[i], ed[i]);
          end
        end
        foreach (fa[i]) begin
          checks++;
          if (w2a[i] !== fa[i] || w2d[i] !== fd[i]
              || w2c[i] !== acc_cyc[fat[i]]) begin
            errors++;
            $display("FAIL rnd%0d_we2[%0d]: a=%0d d=%h want %0d %h",
                     it, i, w2a[i], w2d[i], fa[i], fd[i]);
          end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_bad_csum();
    test_bad_header();
    test_bad_pointer();
    test_throttle();
    test_mid_reset();
    test_random(40);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/bdd_tree_loader.md
# bdd_tree_loader

Streaming writer that programs the decision-tree node memories read by the traversal engine. It accepts a byte-wide valid/ready stream carrying a framed tree image and unpacks each node into one coefficient word (RAM1 write port) and one child-pointer word (RAM2 write port). It then verifies a trailing XOR checksum and flags the image as loaded or corrupt. It sits between the host/config interface and the two node SRAMs, and owns their write ports while `busy` is high.

## Interface
- `RAM1_DATA_WIDTH`, 34: coefficient word width, laid out as {c1[7:0], c2[7:0], c3[7:0], thresh[9:0]}.
- `RAM2_DATA_WIDTH`, 16: child word width, laid out as {left[7:0], right[7:0]}. Bit 7 of each child byte is the leaf flag; bits [6:0] are the class (leaf) or node index (non-leaf).
- `ADDR_WIDTH`, 4: node address width.
- `DEPTH`, 16: node capacity. Must satisfy DEPTH ≤ 2**ADDR_WIDTH and DEPTH ≤ 128.

Ports:
- `clk`  in  1  single clock.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  one-cycle pulse that arms a new load. Honoured only in IDLE, DONE or ERR.
- `s_data`  in  8  stream byte.
- `s_valid`  in  1  byte valid.
- `s_ready`  out  1  loader accepts a byte. A byte transfers on `s_valid & s_ready`.
- `we1`  out  1  RAM1 write strobe.
- `ram1_addr`  out  ADDR_WIDTH  RAM1 write address.
- `ram1_data`  out  RAM1_DATA_WIDTH  RAM1 write data.
- `we2`  out  1  RAM2 write strobe.
- `ram2_addr`  out  ADDR_WIDTH  RAM2 write address.
- `ram2_data`  out  RAM2_DATA_WIDTH  RAM2 write data.
- `busy`  out  1  load in progress.
- `done`  out  1  sticky: image loaded and checksum good.
- `err`  out  1  sticky: image rejected.

## Operation
- Frame, in byte order:
  - Header byte N, the node count.
  - N node records of 7 bytes each: 5 coefficient bytes (big-endian; bits [7:2] of byte 0 ignored), then 2 child bytes (left, then right).
  - 1 checksum byte. The XOR of all frame bytes, checksum included, must equal 0x00.
- States and transitions:
  - IDLE → HDR on `start`.
  - HDR: N == 0 or N > DEPTH → ERR; otherwise → COEF with node index 0.
  - COEF (byte count 0..4) → CHILD after 5 bytes.
  - CHILD (byte count 0..1) → COEF at the next node, or → CSUM once node N-1 completes.
  - CSUM: running XOR == 0 → DONE, else → ERR.
  - DONE/ERR → HDR on `start`.
- Pointer check: a non-leaf child byte whose index is ≥ N sends the FSM to ERR. The check happens when that byte is accepted, and the child word is not written.
- Writes:
  - `we1` pulses for one cycle with `ram1_addr` = node index once coefficient byte 4 is accepted.
  - `we2` pulses likewise once child byte 1 is accepted and passes the pointer check.
- Nodes written before an ERR stay in the RAMs. `done` low signals that the traversal engine must not run.
- `start` is ignored while `busy`.

## Timing
- Reset values:
  - `s_ready`, `we1`, `we2`, `busy`, `done`, `err` = 0.
  - Address and data outputs = 0.
  - State = IDLE, running XOR = 0.
- `s_ready` is registered. It is 1 in HDR/COEF/CHILD/CSUM and 0 elsewhere, so the loader accepts one byte per cycle with no bubbles.
- `start` in cycle t: `busy` = 1 and `s_ready` = 1 from t+1. `done` and `err` clear at t+1, and the XOR clears.
- Write latency:
  - Final coefficient byte accepted in cycle t: `we1`, `ram1_addr` and `ram1_data` are valid in t+1.
  - `we2` follows the same rule for the final child byte.
- Checksum byte accepted in cycle t: `done` or `err` is set in t+1, and `busy` and `s_ready` drop in t+1.
- Any ERR transition sets `err` and clears `busy`/`s_ready` the next cycle.
- Bytes presented while `s_ready` = 0 are not consumed.
- `rst` asserted mid-frame: all outputs reach their reset values asynchronously, and no write strobe fires after reset asserts.
- Node index counts to at most N-1 and does not wrap, because N ≤ DEPTH is enforced at HDR.

## Structure
- Shared package `bdd_pkg`, used by both the traversal engine and the loader:
  - state enum;
  - field offsets for the coefficient and child words;
  - `LEAF_BIT` = 7;
  - `COEF_BYTES` = 5, `CHILD_BYTES` = 2.
- Natural sub-module: `byte_packer`, a shift register that assembles k bytes into a word and reports when complete. It is instantiated twice, once for coefficients and once for children.

## Test plan
- N=1 frame, bytes 01 03 AA BB CC DD 81 82 01:
  - `we1` with addr 0, data 34'h3_AABBCCDD;
  - `we2` with addr 0, data 16'h8182;
  - `done` = 1, `err` = 0.
- Same frame with checksum byte 00: both writes occur, then `err` = 1, `done` = 0.
- Header byte 00, and separately header DEPTH+1: `err` = 1 one cycle after the header, no write strobes.
- N=2 frame with a node-0 left child of 0x05 (non-leaf, index ≥ 2): `we1` for node 0 fires, `we2` does not, `err` = 1.
- N=2 valid frame with `s_valid` toggled every other cycle: writes go to addresses 0 then 1, `done` = 1, and no byte is lost or duplicated.
- `rst` pulsed after the 3rd coefficient byte: all outputs are 0 and no `we1`. A subsequent `start` plus a valid frame completes with `done` = 1.
